spi_serf: RTL

//  SPI serf (responder) for SPI_mnrch frames. Fixed at 16 bits, MSB first.

---
 rtl/spi_serf_if.sv | 25 ++
 rtl/spi_serf.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/spi_serf_if.sv
// Bundled serial pins and host-side word signals for the spi_serf responder.
// The master modport is the side that drives the frame: the monarch pins plus the local host.
interface spi_serf_if #(
    parameter int DATA_W = 16
);
    logic              SS_n;
    logic              SCLK;
    logic              MOSI;
    logic              MISO;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic              rdy;
    logic              clr_rdy;
    logic              frm_err;

    modport slave (
        input  SS_n, SCLK, MOSI, tx_data, clr_rdy,
        output MISO, rx_data, rdy, frm_err
    );

    modport master (
        output SS_n, SCLK, MOSI, tx_data, clr_rdy,
        input  MISO, rx_data, rdy, frm_err
    );
endinterface

// File: rtl/spi_serf.sv
// SPI responder: oversamples SS_n/SCLK/MOSI, shifts in a DATA_W-bit word MSB first and returns tx_data on MISO.
// Optional feature macro SPI_SERF_FRM_ERR_EN enables the frm_err pulse on a frame of the wrong length.
module spi_serf #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    spi_serf_if.slave  bus
);
    localparam int                CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DATA_W);
    localparam int                MOSI_IDX = 0;
    localparam int                SCLK_IDX = 1;
    localparam int                SS_IDX   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    logic [2:0] raw_in;
    logic [2:0] sync_s;
    logic [2:1] hist_s;

    assign raw_in = {bus.SS_n, bus.SCLK, bus.MOSI};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    chain_q <= '1;
                end else begin
                    chain_q <= {chain_q[SYNC_STAGES-2:0], raw_in[gi]};
                end
            end

            assign sync_s[gi] = chain_q[SYNC_STAGES-1];

            // MOSI is only ever sampled, so only the edge-detected inputs carry a history flop.
            if (gi != MOSI_IDX) begin : g_hist
                logic hist_q;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        hist_q <= 1'b1;
                    end else begin
                        hist_q <= chain_q[SYNC_STAGES-1];
                    end
                end

                assign hist_s[gi] = hist_q;
            end
        end
    endgenerate

    logic ss_s;
    logic mosi_s;
    logic ss_fall;
    logic ss_rise;
    logic sclk_fall;
    logic sclk_rise;

    assign ss_s      = sync_s[SS_IDX];
    assign mosi_s    = sync_s[MOSI_IDX];
    assign ss_fall   =  hist_s[SS_IDX]   & ~sync_s[SS_IDX];
    assign ss_rise   = ~hist_s[SS_IDX]   &  sync_s[SS_IDX];
    assign sclk_fall =  hist_s[SCLK_IDX] & ~sync_s[SCLK_IDX];
    assign sclk_rise = ~hist_s[SCLK_IDX] &  sync_s[SCLK_IDX];

    // The synchronizer output only carries a real pin sample SYNC_STAGES clocks after reset.
    // A frame may start only once a genuine high SS_n has been seen, so an SS_n held low
    // across reset release never looks like a frame start.
    logic [SYNC_STAGES-1:0] valid_q;
    logic                   armed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            armed_q <= 1'b0;
        end else begin
            valid_q <= {valid_q[SYNC_STAGES-2:0], 1'b1};
            armed_q <= armed_q | (ss_s & valid_q[SYNC_STAGES-1]);
        end
    end

    state_t            state_q,   state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_shft_q, rx_shft_d;
    logic [DATA_W-1:0] tx_shft_q, tx_shft_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rdy_q,     rdy_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_shft_d = rx_shft_q;
        tx_shft_d = tx_shft_q;
        rx_data_d = rx_data_q;
        rdy_d     = rdy_q & ~bus.clr_rdy;

        unique case (state_q)
            IDLE: begin
                if (ss_fall && armed_q) begin
                    state_d   = XFER;
                    bit_cnt_d = '0;
                end else begin
                    tx_shft_d = bus.tx_data;
                end
            end
            XFER: begin
                if (sclk_rise) begin
                    rx_shft_d = {rx_shft_q[DATA_W-2:0], mosi_s};
                    if (bit_cnt_q != '1) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                // The fall ahead of the first rise must leave the MSB on MISO.
                if (sclk_fall && (bit_cnt_q != '0)) begin
                    tx_shft_d = tx_shft_q << 1;
                end
                // Frame check uses the count after any edge in this same clock.
                if (ss_rise) begin
                    state_d = IDLE;
                    if (bit_cnt_d == FULL_CNT) begin
                        rx_data_d = rx_shft_d;
                        rdy_d     = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            rx_shft_q <= '0;
            tx_shft_q <= '0;
            rx_data_q <= '0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_shft_q <= rx_shft_d;
            tx_shft_q <= tx_shft_d;
            rx_data_q <= rx_data_d;
            rdy_q     <= rdy_d;
        end
    end

`ifdef SPI_SERF_FRM_ERR_EN
    logic frm_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frm_err_q <= 1'b0;
        end else begin
            frm_err_q <= (state_q == XFER) && ss_rise && (bit_cnt_d != FULL_CNT);
        end
    end

    assign bus.frm_err = frm_err_q;
`else
    assign bus.frm_err = 1'b0;
`endif

    assign bus.MISO    = tx_shft_q[DATA_W-1];
    assign bus.rx_data = rx_data_q;
    assign bus.rdy     = rdy_q;
endmodule
